coeff_loader: RTL and testbench

//  Command decoder and coefficient register bank between the SPI slave byte interface and the
//  HP/LP biquad filters. Assembles 64-bit coefficients from SPI bytes into a shadow bank.

---
 rtl/channel_strip_pkg.sv | 53 +++++
 rtl/coeff_bank.sv | 45 ++++
 rtl/coeff_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_coeff_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/channel_strip_pkg.sv
// Shared types and constants for the channel-strip coefficient loader:
// SPI opcodes, loader FSM states, coefficient type/indices and reset values.
package channel_strip_pkg;

   localparam int NUM_COEFF  = 10;
   localparam int COEFF_W    = 64;
   localparam int COEFF_FRAC = 60;

   // First index that is out of range, as a command-sized value.
   localparam logic [3:0] IDX_LIMIT = 4'd10;

   localparam int HP_Y1 = 0;
   localparam int HP_Y2 = 1;
   localparam int HP_X0 = 2;
   localparam int HP_X1 = 3;
   localparam int HP_X2 = 4;
   localparam int LP_Y1 = 5;
   localparam int LP_Y2 = 6;
   localparam int LP_X0 = 7;
   localparam int LP_X1 = 8;
   localparam int LP_X2 = 9;

   typedef logic signed [COEFF_W-1:0] coeff_t;

   // Unity gain in Q3.60.
   localparam coeff_t PASSTHRU_X0 = coeff_t'(64'h1000_0000_0000_0000);

   typedef enum logic [3:0] {
      OP_AUDIO   = 4'h0,
      OP_WRITE   = 4'h2,
      OP_COMMIT  = 4'h3,
      OP_CLR_ERR = 4'h4,
      OP_READ    = 4'h5
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_SKIP,
      ST_COMMIT,
      ST_CLR_ERR
   } state_e;

   // Passthrough biquad: only the x0 taps are non-zero.
   function automatic coeff_t reset_coeff(input int idx);
      if (idx == HP_X0 || idx == LP_X0) begin
         return PASSTHRU_X0;
      end
      return '0;
   endfunction

endpackage

// File: rtl/coeff_bank.sv
// Shadow and active coefficient arrays. Purpose: hold the bank being
// edited (shadow) and the bank the filters use (active), copied atomically.
// Ports: i_clk, i_reset (sync, high); i_wr_en/i_wr_idx/i_wr_data write
// one shadow entry; i_commit copies all of shadow to active in one cycle;
// o_coeff is the packed active bank, entry i at [i*COEFF_W +: COEFF_W].
module coeff_bank
   import channel_strip_pkg::*;
(
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_wr_en,
   input  logic [3:0]                   i_wr_idx,
   input  logic [COEFF_W-1:0]           i_wr_data,
   input  logic                         i_commit,
   output logic [NUM_COEFF*COEFF_W-1:0] o_coeff
);

   coeff_t r_shadow [NUM_COEFF];
   coeff_t r_active [NUM_COEFF];

   // The copy reads shadow before this cycle's write lands, so a write
   // racing a commit stays pending for the next one.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_COEFF; i++) begin
            r_shadow[i] <= reset_coeff(i);
            r_active[i] <= reset_coeff(i);
         end
      end else begin
         for (int i = 0; i < NUM_COEFF; i++) begin
            if (i_commit) begin
               r_active[i] <= r_shadow[i];
            end
            if (i_wr_en && i_wr_idx == 4'(i)) begin
               r_shadow[i] <= i_wr_data;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_COEFF; g++) begin : g_pack
      assign o_coeff[g*COEFF_W +: COEFF_W] = r_active[g];
   end

endmodule

// File: rtl/coeff_loader.sv
// SPI command decoder feeding the biquad coefficient bank. Purpose: parse
// {op,idx} command bytes, assemble 64-bit words MSB first into the shadow
// bank, and commit the bank to the filters on a sample_tick boundary.
// Ports: i_clk, i_reset (sync, high), i_sample_tick, i_rx_valid/i_rx_data,
// i_frame_end, i_tx_ready in; o_tx_valid/o_tx_data readback,
// o_coeff packed active bank, o_commit_pend, o_err (sticky) out.
// Build option: COEFF_LOADER_READBACK_EN enables OP_READ byte streaming;
// without it OP_READ is an invalid opcode and the tx outputs read 0.
module coeff_loader
   import channel_strip_pkg::*;
(
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_sample_tick,
   input  logic                         i_rx_valid,
   input  logic [7:0]                   i_rx_data,
   input  logic                         i_frame_end,
   input  logic                         i_tx_ready,
   output logic                         o_tx_valid,
   output logic [7:0]                   o_tx_data,
   output logic [NUM_COEFF*COEFF_W-1:0] o_coeff,
   output logic                         o_commit_pend,
   output logic                         o_err
);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [3:0]          r_idx;
   logic [2:0]          r_cnt;
   logic [COEFF_W-1:0]  r_shift;
   logic                r_commit_pend;
   logic                r_err;

   logic [3:0]          w_op;
   logic [3:0]          w_cmd_idx;
   logic                w_idx_ok;
   logic [COEFF_W-1:0]  w_wr_data;
   logic                w_cmd_cap;
   logic                w_shift_en;
   logic                w_wr_en;
   logic                w_set_pend;
   logic                w_set_err;
   logic                w_clr_err;
   logic                w_commit;

`ifdef COEFF_LOADER_READBACK_EN
   logic [COEFF_W-1:0]  r_rd_word;
   logic [2:0]          r_rd_cnt;
   logic [COEFF_W-1:0]  w_rd_sel;
   logic                w_rd_load;
   logic                w_rd_adv;
`else
   logic                w_unused_tx_ready;
   assign w_unused_tx_ready = i_tx_ready;
`endif

   assign w_op      = i_rx_data[7:4];
   assign w_cmd_idx = i_rx_data[3:0];
   assign w_idx_ok  = (w_cmd_idx < IDX_LIMIT);
   assign w_wr_data = {r_shift[COEFF_W-9:0], i_rx_data};
   assign w_commit  = i_sample_tick & r_commit_pend;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_cap   = 1'b0;
      w_shift_en  = 1'b0;
      w_wr_en     = 1'b0;
      w_set_pend  = 1'b0;
      w_set_err   = 1'b0;
      w_clr_err   = 1'b0;
      o_tx_valid  = 1'b0;
      o_tx_data   = 8'h00;
`ifdef COEFF_LOADER_READBACK_EN
      w_rd_load   = 1'b0;
      w_rd_adv    = 1'b0;
`endif
      unique case (r_state)
         ST_IDLE: begin
            if (i_rx_valid) begin
               w_cmd_cap = 1'b1;
               unique case (w_op)
                  OP_AUDIO: begin
                     w_state_nxt = ST_SKIP;
                  end
                  OP_WRITE: begin
                     if (w_idx_ok) begin
                        w_state_nxt = ST_WRITE;
                     end else begin
                        w_set_err   = 1'b1;
                        w_state_nxt = ST_SKIP;
                     end
                  end
                  OP_COMMIT: begin
                     w_state_nxt = ST_COMMIT;
                  end
                  OP_CLR_ERR: begin
                     w_state_nxt = ST_CLR_ERR;
                  end
`ifdef COEFF_LOADER_READBACK_EN
                  OP_READ: begin
                     if (w_idx_ok) begin
                        w_rd_load   = 1'b1;
                        w_state_nxt = ST_READ;
                     end else begin
                        w_set_err   = 1'b1;
                        w_state_nxt = ST_SKIP;
                     end
                  end
`endif
                  default: begin
                     w_set_err   = 1'b1;
                     w_state_nxt = ST_SKIP;
                  end
               endcase
            end
         end
         ST_WRITE: begin
            if (i_rx_valid) begin
               w_shift_en = 1'b1;
               if (r_cnt == 3'd7) begin
                  w_wr_en     = 1'b1;
                  w_state_nxt = ST_SKIP;
               end
            end
         end
         ST_READ: begin
`ifdef COEFF_LOADER_READBACK_EN
            o_tx_valid = 1'b1;
            o_tx_data  = r_rd_word[COEFF_W-1 -: 8];
            if (i_tx_ready) begin
               w_rd_adv = 1'b1;
               if (r_rd_cnt == 3'd7) begin
                  w_state_nxt = ST_SKIP;
               end
            end
`else
            w_state_nxt = ST_SKIP;
`endif
         end
         ST_COMMIT: begin
            w_set_pend  = 1'b1;
            w_state_nxt = ST_SKIP;
         end
         ST_CLR_ERR: begin
            w_clr_err   = 1'b1;
            w_state_nxt = ST_SKIP;
         end
         ST_SKIP: begin
            w_state_nxt = ST_SKIP;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // CS release ends the frame whatever was in flight.
      if (i_frame_end) begin
         w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_idx         <= '0;
         r_cnt         <= '0;
         r_shift       <= '0;
         r_commit_pend <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         if (w_cmd_cap) begin
            r_idx <= w_cmd_idx;
            r_cnt <= '0;
         end else if (w_shift_en) begin
            r_cnt   <= r_cnt + 3'd1;
            r_shift <= w_wr_data;
         end
         // A commit arriving with the tick is honoured on the next tick.
         r_commit_pend <= (r_commit_pend & ~i_sample_tick) | w_set_pend;
         if (w_set_err) begin
            r_err <= 1'b1;
         end else if (w_clr_err) begin
            r_err <= 1'b0;
         end
      end
   end

`ifdef COEFF_LOADER_READBACK_EN
   always_comb begin
      w_rd_sel = '0;
      for (int i = 0; i < NUM_COEFF; i++) begin
         if (w_cmd_idx == 4'(i)) begin
            w_rd_sel = o_coeff[i*COEFF_W +: COEFF_W];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_word <= '0;
         r_rd_cnt  <= '0;
      end else if (w_rd_load) begin
         r_rd_word <= w_rd_sel;
         r_rd_cnt  <= '0;
      end else if (w_rd_adv) begin
         r_rd_word <= {r_rd_word[COEFF_W-9:0], 8'h00};
         r_rd_cnt  <= r_rd_cnt + 3'd1;
      end
   end
`endif

   coeff_bank u_bank (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (r_idx),
      .i_wr_data (w_wr_data),
      .i_commit  (w_commit),
      .o_coeff   (o_coeff)
   );

   assign o_commit_pend = r_commit_pend;
   assign o_err         = r_err;

endmodule

// File: tb/tb_coeff_loader.sv
// Directed self-checking bench for coeff_loader.
// Drives SPI command frames and sample ticks, checks bank and flags.
module tb_coeff_loader;

   logic         i_clk = 1'b0;
   logic         i_reset;
   logic         i_sample_tick;
   logic         i_rx_valid;
   logic [7:0]   i_rx_data;
   logic         i_frame_end;
   logic         i_tx_ready;
   logic         o_tx_valid;
   logic [7:0]   o_tx_data;
   logic [639:0] o_coeff;
   logic         o_commit_pend;
   logic         o_err;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [63:0] UNITY = 64'h1000_0000_0000_0000;

   coeff_loader dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_sample_tick (i_sample_tick),
      .i_rx_valid    (i_rx_valid),
      .i_rx_data     (i_rx_data),
      .i_frame_end   (i_frame_end),
      .i_tx_ready    (i_tx_ready),
      .o_tx_valid    (o_tx_valid),
      .o_tx_data     (o_tx_data),
      .o_coeff       (o_coeff),
      .o_commit_pend (o_commit_pend),
      .o_err         (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] cf(input int i);
      return o_coeff[i*64 +: 64];
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      step();
      i_rx_valid = 1'b0;
      i_rx_data  = 8'h00;
   endtask

   task automatic fend();
      i_frame_end = 1'b1;
      step();
      i_frame_end = 1'b0;
   endtask

   task automatic stick();
      i_sample_tick = 1'b1;
      step();
      i_sample_tick = 1'b0;
   endtask

   task automatic wr_word(input logic [3:0] idx, input logic [63:0] w);
      send({4'h2, idx});
      for (int k = 7; k >= 0; k--) send(w[k*8 +: 8]);
      fend();
   endtask

   task automatic commit_frame();
      send(8'h30);
      step();
      fend();
      stick();
   endtask

   logic [7:0] rb [8];
   int         nrx;

   initial begin
      i_reset       = 1'b1;
      i_sample_tick = 1'b0;
      i_rx_valid    = 1'b0;
      i_rx_data     = 8'h00;
      i_frame_end   = 1'b0;
      i_tx_ready    = 1'b0;
      step();
      step();
      i_reset = 1'b0;
      step();

      // 1: reset state is passthrough
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("rst_coeff%0d", i), cf(i),
             (i == 2 || i == 7) ? UNITY : 64'h0);
      end
      chk("rst_err", 64'(o_err), 64'h0);
      chk("rst_pend", 64'(o_commit_pend), 64'h0);
      chk("rst_txv", 64'(o_tx_valid), 64'h0);
      chk("rst_txd", 64'(o_tx_data), 64'h0);

      // 2: write idx 7 then commit on next tick
      wr_word(4'd7, 64'h0102030405060708);
      chk("wr7_active_unchanged", cf(7), UNITY);
      send(8'h30);
      step();
      chk("pend_set", 64'(o_commit_pend), 64'h1);
      step();
      step();
      chk("pend_hold", 64'(o_commit_pend), 64'h1);
      chk("pre_tick_coeff7", cf(7), UNITY);
      fend();
      stick();
      chk("commit_coeff7", cf(7), 64'h0102030405060708);
      chk("pend_clr", 64'(o_commit_pend), 64'h0);
      chk("commit_coeff2", cf(2), UNITY);

      // 3: partial word discarded, full word captured
      send(8'h21);
      send(8'hAA);
      send(8'hBB);
      send(8'hCC);
      fend();
      commit_frame();
      chk("partial_coeff1", cf(1), 64'h0);
      wr_word(4'd1, 64'h1112131415161718);
      commit_frame();
      chk("full_coeff1", cf(1), 64'h1112131415161718);

      // 4: bad index sets err, nothing written; clear err
      send(8'h2C);
      chk("badidx_err", 64'(o_err), 64'h1);
      for (int k = 0; k < 8; k++) send(8'h99);
      fend();
      commit_frame();
      chk("badidx_coeff1", cf(1), 64'h1112131415161718);
      chk("badidx_coeff7", cf(7), 64'h0102030405060708);
      chk("badidx_coeff9", cf(9), 64'h0);
      send(8'h40);
      step();
      chk("clr_err", 64'(o_err), 64'h0);
      fend();

      // 5: commit coinciding with tick copies on the following tick
      wr_word(4'd0, 64'hDEADBEEF00112233);
      i_rx_valid    = 1'b1;
      i_rx_data     = 8'h30;
      i_sample_tick = 1'b1;
      step();
      i_rx_valid = 1'b0;
      i_rx_data  = 8'h00;
      step();
      i_sample_tick = 1'b0;
      chk("sametick_no_copy", cf(0), 64'h0);
      chk("sametick_pend", 64'(o_commit_pend), 64'h1);
      fend();
      stick();
      chk("nexttick_copy", cf(0), 64'hDEADBEEF00112233);

      // 6: readback
      wr_word(4'd2, 64'hA1A2A3A4A5A6A7A8);
      commit_frame();
      chk("rb_src_coeff2", cf(2), 64'hA1A2A3A4A5A6A7A8);
`ifdef COEFF_LOADER_READBACK_EN
      send(8'h52);
      nrx = 0;
      for (int c = 0; c < 40 && nrx < 8; c++) begin
         i_tx_ready = c[0];
         #1;
         if (o_tx_valid && i_tx_ready) begin
            rb[nrx] = o_tx_data;
            nrx++;
         end
         step();
      end
      i_tx_ready = 1'b0;
      chk("rb_count", 64'(nrx), 64'd8);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("rb_byte%0d", k), 64'(rb[k]), 64'(8'hA1 + k));
      end
      chk("rb_done_txv", 64'(o_tx_valid), 64'h0);
      chk("rb_err", 64'(o_err), 64'h0);
      fend();
`else
      send(8'h52);
      chk("rd_disabled_err", 64'(o_err), 64'h1);
      for (int c = 0; c < 4; c++) begin
         i_tx_ready = c[0];
         step();
         chk($sformatf("rd_disabled_txv%0d", c), 64'(o_tx_valid), 64'h0);
      end
      i_tx_ready = 1'b0;
      fend();
`endif

      // reset mid-frame, next byte is a command
      send(8'h21);
      send(8'h55);
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      chk("midrst_coeff0", cf(0), 64'h0);
      chk("midrst_coeff2", cf(2), UNITY);
      chk("midrst_err", 64'(o_err), 64'h0);
      send(8'hF0);
      chk("midrst_cmd_err", 64'(o_err), 64'h1);
      fend();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
